// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer between the pc register and decode.
// Issues one instruction-memory request at a time over a req/gnt/rvalid
// handshake, advances the pc register on each grant, and hands fetched words
// to decode through a one-entry valid/ready buffer. Redirects from execute
// discard any fetch that is in flight or buffered.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        pc_write_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  logic        kill;        // outstanding response belongs to a discarded path
  logic [31:0] req_pc;      // PC of the request currently outstanding
  logic        redirect_taken;
  logic        grant;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'h0000_0003;
  assign imem_addr        = pc_in & ~32'h0000_0003;

  // Request and pc-update strobes; a redirect suppresses the request so any grant is moot.
  always_comb begin
    imem_req       = (state == S_REQ) && !redirect_valid;
    redirect_taken = redirect_valid && (state != S_IDLE);
    grant          = imem_req && imem_gnt;
    pc_write_en    = redirect_taken || grant;
    pc_next        = redirect_taken ? redirect_aligned : (pc_in + 32'd4);
  end

  // Fetch sequencer and decode-side buffer; redirects flush stale work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      kill     <= 1'b0;
      req_pc   <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= RESET_PC;
      id_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
        end
        S_REQ: begin
          // A redirect just retargets the pc; the new address is requested next cycle.
          if (grant) begin
            req_pc <= pc_in;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            kill <= 1'b0;
            if (kill || redirect_valid) begin
              state <= S_REQ;
            end else begin
              id_instr <= imem_rdata;
              id_pc    <= req_pc;
              id_fault <= imem_err;
              id_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end else if (redirect_valid) begin
            // Response still pending: remember to throw it away when it lands.
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            state    <= S_REQ;
          end else if (id_ready) begin
            id_valid <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by a randomized run against a
// transaction-level model: delivered instructions must form a sequential
// stream starting at the last redirect target, with words and faults taken
// from a behavioural instruction memory with random latency.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        pc_write_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_q),
    .pc_next        (pc_next),
    .pc_write_en    (pc_write_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_fault       (id_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pc register fed by the fetch unit.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= 32'h0;
    else if (pc_write_en) pc_q <= pc_next;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return (w[7:4] == 4'h0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        pending;
  int          lat;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  int          delivered;
  logic [31:0] held_instr;

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_pc_we", pc_write_en, 0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_fault", id_fault, 0);
    rst = 1'b1;
    #1 chk("idle_req", imem_req, 0);
    @(negedge clk); #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);

    // Zero-wait fetch
    imem_gnt = 1'b1; #1;
    chk("zw_pc_we", pc_write_en, 1);
    chk("zw_pc_next", pc_next, 32'h4);
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
    chk("zw_wait_req", imem_req, 0);
    chk("zw_wait_pc_we", pc_write_en, 0);
    @(negedge clk); imem_rvalid = 1'b0; imem_rdata = 32'h0; #1;
    chk("zw_id_valid", id_valid, 1);
    chk("zw_id_pc", id_pc, 32'h0);
    chk("zw_id_instr", id_instr, 32'h0050_0093);
    chk("zw_id_fault", id_fault, 0);
    chk("zw_pc_reg", pc_q, 32'h4);

    // Backpressure
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("bp_id_valid", id_valid, 1);
      chk("bp_id_instr", id_instr, 32'h0050_0093);
      chk("bp_req", imem_req, 0);
    end
    id_ready = 1'b1;
    @(negedge clk); id_ready = 1'b0; #1;
    chk("bp_release_valid", id_valid, 0);
    chk("bp_next_req", imem_req, 1);
    chk("bp_next_addr", imem_addr, 32'h4);

    // Fetch at 0x4 to advance to 0x8
    imem_gnt = 1'b1; #1 chk("f4_pc_next", pc_next, 32'h8);
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
    @(negedge clk); imem_rvalid = 1'b0; #1;
    chk("f4_id_pc", id_pc, 32'h4);
    chk("f4_id_instr", id_instr, 32'h0010_0113);
    id_ready = 1'b1;
    @(negedge clk); id_ready = 1'b0;

    // Grant stall
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("gs_req", imem_req, 1);
      chk("gs_addr", imem_addr, 32'h8);
      chk("gs_pc_we", pc_write_en, 0);
      @(negedge clk);
    end
    imem_gnt = 1'b1; #1;
    chk("gs_grant_we", pc_write_en, 1);
    chk("gs_grant_next", pc_next, 32'hC);
    @(negedge clk); imem_gnt = 1'b0;

    // Redirect while waiting, then a stale response
    redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
    chk("rw_pc_we", pc_write_en, 1);
    chk("rw_pc_next", pc_next, 32'h100);
    chk("rw_req", imem_req, 0);
    @(negedge clk); redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("rw_stale_req", imem_req, 0);
    @(negedge clk); imem_rvalid = 1'b0; #1;
    chk("rw_id_valid", id_valid, 0);
    chk("rw_req_after", imem_req, 1);
    chk("rw_addr_after", imem_addr, 32'h100);

    // Errored fetch
    imem_gnt = 1'b1; #1 chk("err_pc_next", pc_next, 32'h104);
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_err = 1'b1; imem_rdata = 32'h0BAD_C0DE;
    @(negedge clk); imem_rvalid = 1'b0; imem_err = 1'b0; #1;
    chk("err_id_valid", id_valid, 1);
    chk("err_id_fault", id_fault, 1);
    chk("err_id_pc", id_pc, 32'h100);
    id_ready = 1'b1;
    @(negedge clk); id_ready = 1'b0; #1;
    chk("err_next_addr", imem_addr, 32'h104);
    imem_gnt = 1'b1;
    @(negedge clk); imem_gnt = 1'b0;

    // Asynchronous reset in WAIT, then a late response
    #2 rst = 1'b0; #1;
    chk("ar_id_instr", id_instr, 32'h0000_0013);
    chk("ar_id_pc", id_pc, 32'h0);
    chk("ar_id_fault", id_fault, 0);
    chk("ar_id_valid", id_valid, 0);
    chk("ar_req", imem_req, 0);
    chk("ar_pc_we", pc_write_en, 0);
    @(negedge clk); rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    chk("ar_req_after", imem_req, 1);
    chk("ar_addr_after", imem_addr, 32'h0);
    @(negedge clk); imem_rvalid = 1'b0; #1;
    chk("ar_late_valid", id_valid, 0);

    // Redirect in REQ beats a grant; wrap of the increment
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; imem_gnt = 1'b1; #1;
    chk("rr_req", imem_req, 0);
    chk("rr_pc_we", pc_write_en, 1);
    chk("rr_pc_next", pc_next, 32'hFFFF_FFFC);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_next", pc_next, 32'h0);
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0073;
    @(negedge clk); imem_rvalid = 1'b0; #1;
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_instr", id_instr, 32'h0000_0073);

    // Redirect in HOLD flushes the buffer
    redirect_valid = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1; #1;
    chk("rh_pc_next", pc_next, 32'h200);
    @(negedge clk); redirect_valid = 1'b0; id_ready = 1'b0; #1;
    chk("rh_id_valid", id_valid, 0);
    chk("rh_id_instr", id_instr, 32'h0000_0013);
    chk("rh_addr", imem_addr, 32'h200);

    // Randomized run against the stream model
    pending = 1'b0; lat = 0; pend_addr = 32'h0; exp_pc = 32'h0; delivered = 0;
    held_instr = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      redirect_valid = (c == 0) || ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      id_ready       = ($urandom_range(0, 1) == 1);
      imem_gnt       = ($urandom_range(0, 2) != 0);
      if (pending && lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        imem_err    = mem_err(pend_addr);
        pending     = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        imem_err    = ($urandom_range(0, 1) == 1);
        if (pending) lat--;
      end
      #1;
      if (redirect_valid) begin
        chk("rnd_redir_req", imem_req, 0);
        chk("rnd_redir_we", pc_write_en, 1);
        chk("rnd_redir_next", pc_next, redirect_pc & ~32'h3);
      end else if (imem_req) begin
        chk("rnd_addr", imem_addr, pc_q & ~32'h3);
        chk("rnd_one_outstanding", {31'd0, pending}, 32'd0);
        chk("rnd_grant_we", pc_write_en, imem_gnt);
        if (imem_gnt) chk("rnd_grant_next", pc_next, pc_q + 32'd4);
      end else begin
        chk("rnd_idle_we", pc_write_en, 0);
      end
      if (imem_req && imem_gnt && !redirect_valid) begin
        pending   = 1'b1;
        lat       = $urandom_range(0, 2);
        pend_addr = imem_addr;
      end
      if (id_valid && id_ready && !redirect_valid) begin
        chk("rnd_id_pc", id_pc, exp_pc);
        chk("rnd_id_instr", id_instr, mem_word(exp_pc));
        chk("rnd_id_fault", id_fault, mem_err(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    end
    chk("rnd_progress", delivered >= 40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
